// File: rtl/seq_alu.sv
// Registered multicycle ALU with start/busy/done handshake; MUL and DIVU/REMU iterate WIDTH cycles.
// Optional signed-overflow output V is enabled by defining SEQ_ALU_OVERFLOW_EN.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       F,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic             Zero,
    output logic             busy,
    output logic             done
`ifdef SEQ_ALU_OVERFLOW_EN
    ,
    output logic             V
`endif
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [SHW:0]     cnt;
    logic [3:0]       f_q;
    logic [WIDTH-1:0] acc, opa, opb;
    logic [WIDTH-1:0] acc_nx, opa_nx, opb_nx;
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] res;
    logic [SHW-1:0]   shamt;
    logic             is_multi;
    logic             last;

    assign shamt    = B[SHW-1:0];
    assign is_multi = (F == OP_MUL) || (F == OP_DIVU) || (F == OP_REMU);
    assign last     = (cnt == CNT_ONE);
    assign Zero     = (Y == '0);

    always_comb begin
        res = '0;
        case (F)
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_ADD:  res = A + B;
            OP_SUB:  res = A - B;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_XOR:  res = A ^ B;
            OP_NOR:  res = ~(A | B);
            OP_SLL:  res = A << shamt;
            OP_SRL:  res = A >> shamt;
            OP_SRA:  res = $unsigned($signed(A) >>> shamt);
            default: res = '0;
        endcase
    end

`ifdef SEQ_ALU_OVERFLOW_EN
    logic ovf;

    always_comb begin
        ovf = 1'b0;
        if (F == OP_ADD)
            ovf = (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
        else if (F == OP_SUB)
            ovf = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
    end
`endif

    // One iteration: acc/opa/opb are multiplier state for MUL, remainder/quotient/divisor for DIV.
    // With a zero divisor every trial succeeds, giving all-ones quotient and remainder == A.
    always_comb begin
        trial  = {acc, opa[WIDTH-1]};
        ge     = (trial >= {1'b0, opb});
        acc_nx = acc;
        opa_nx = opa;
        opb_nx = opb;
        if (f_q == OP_MUL) begin
            acc_nx = opb[0] ? acc + opa : acc;
            opa_nx = opa << 1;
            opb_nx = opb >> 1;
        end else begin
            acc_nx = ge ? trial[WIDTH-1:0] - opb : trial[WIDTH-1:0];
            opa_nx = {opa[WIDTH-2:0], ge};
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start && is_multi) state_nx = RUN;
            RUN:  if (last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Y    <= '0;
            done <= 1'b0;
            cnt  <= '0;
            f_q  <= '0;
            acc  <= '0;
            opa  <= '0;
            opb  <= '0;
`ifdef SEQ_ALU_OVERFLOW_EN
            V    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        f_q <= F;
                        if (is_multi) begin
                            cnt <= CNT_INIT;
                            acc <= '0;
                            opa <= A;
                            opb <= B;
                        end else begin
                            Y    <= res;
                            done <= 1'b1;
`ifdef SEQ_ALU_OVERFLOW_EN
                            V    <= ovf;
`endif
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_ONE;
                    acc <= acc_nx;
                    opa <= opa_nx;
                    opb <= opb_nx;
                    if (last) begin
                        Y    <= (f_q == OP_DIVU) ? opa_nx : acc_nx;
                        done <= 1'b1;
`ifdef SEQ_ALU_OVERFLOW_EN
                        V    <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered ALU; next generation of the multicycle datapath's combinational ALU.
- Keeps the legacy 3-bit function encodings in the low bits of a 4-bit function code.
- Adds XOR/NOR, signed/unsigned compare, shifts, and iterative multiply and unsigned divide/remainder.
- Uses a start/busy/done handshake, so the multicycle controller can stall on long ops; sits between the operand muxes (SrcA/SrcB) and ALUOut.

Parameters:
- WIDTH, 32, datapath width in bits. Must be a power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width. Derived localparam; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE; latches A, B and F.
- F  input  4  function code.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Y  output  WIDTH  registered result. Holds its value until the next done.
- Zero  output  1  combinational, (Y == 0), derived from registered Y.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when Y is updated.

Behaviour:
- Function codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 0111 SLT (signed, 1/0), 0011 SLTU (unsigned), 0100 XOR, 0101 NOR.
  - 1000 SLL, 1001 SRL, 1010 SRA; shift amount is B[SHW-1:0], upper B bits ignored.
  - 1100 MUL: low WIDTH bits of the product (sign-agnostic).
  - 1110 DIVU: quotient. 1111 REMU: remainder.
  - Any other code (1011, 1101): result 0, single-cycle.
- Arithmetic wraps modulo 2^WIDTH; no carry-out.
- FSM states IDLE, RUN; done is a registered pulse.
- IDLE, start=1, single-cycle op: Y <= result at the next edge, done=1 for that one cycle, remain IDLE. Latency 1.
- IDLE, start=1, MUL/DIVU/REMU: latch operands, load counter = WIDTH, go to RUN.
  - Next state is RUN, so busy=1 in the following cycle.
- RUN: one iteration per cycle.
  - MUL: shift-add, LSB-first.
  - DIVU/REMU: restoring, MSB-first.
  - Counter decrements each cycle. When it reaches 0: Y <= result, done=1, return to IDLE.
  - Latency from the start cycle to done is WIDTH+1 cycles, fixed and independent of operand values.
- Divide by zero (B==0): no trap, same latency. DIVU gives all ones; REMU gives A.
- start while busy is ignored. The controller must wait for done.
- start in the same cycle as done is accepted only if the FSM is in IDLE; back-to-back single-cycle ops give done every cycle.
- A, B and F may change after the start cycle without affecting the in-flight op.
- Y is not updated during RUN; the previous result stays visible until done.
- Reset, including mid-RUN: state IDLE, Y=0, Zero=1, busy=0, done=0, counter cleared. The in-flight op is discarded with no done.

Optional Feature:
- Macro: SEQ_ALU_OVERFLOW_EN.
- Defined:
  - Adds output port V (1 bit), registered with Y and updated on every done.
  - For ADD, V = signed overflow (operands same sign, result differs).
  - For SUB, V = signed overflow (operands differ in sign, result sign differs from A).
  - For all other ops, V = 0. V resets to 0.
- Undefined: port V absent; no other behavioural change.

Test Plan (WIDTH=32):
- Reset held 2 cycles, then released: Y=0, Zero=1, busy=0, done=0. Then start, F=0110, A=5, B=5: next cycle done=1, Y=0, Zero=1.
- Single-cycle ops:
  - SLT, A=0xFFFFFFFF, B=1: Y=1.
  - SLTU, same operands: Y=0.
  - SRA, A=0x80000000, B=0x24 (shift 4): Y=0xF8000000.
- MUL, A=0x00012345, B=0x00010000, pulsed for one cycle then operands changed:
  - busy high for 32 cycles.
  - done exactly 33 cycles after the start cycle.
  - Y=0x23450000.
- DIVU A=100, B=7: Y=14. REMU A=100, B=7: Y=2. DIVU B=0: Y=0xFFFFFFFF. REMU B=0: Y=A. Each completes in 33 cycles.
- Second start asserted mid-RUN: ignored, only one done. Reset asserted at RUN cycle 10: no done, Y=0, IDLE next cycle, fresh ADD then completes in 1 cycle.
- With SEQ_ALU_OVERFLOW_EN:
  - ADD 0x7FFFFFFF+1: V=1, Y=0x80000000.
  - SUB 0x80000000-1: V=1.
  - AND: V=0.
